// File: rtl/sepia_frame_sequencer.sv
// Frame sequencer for an HLS sepia filter: walks every pixel of the R/G/B input
// RAMs, hands each pixel to the filter and writes the result to the output RAMs.
module sepia_frame_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int PIXEL_COUNT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              bram_ena,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  output logic              flt_start,
  input  logic              flt_ready,
  input  logic              flt_done,
  output logic [7:0]        flt_red,
  output logic [7:0]        flt_green,
  output logic [7:0]        flt_blue,
  input  logic [7:0]        flt_new_red,
  input  logic [7:0]        flt_new_green,
  input  logic [7:0]        flt_new_blue,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_red,
  output logic [7:0]        out_green,
  output logic [7:0]        out_blue,
  output logic              busy,
  output logic              frame_done,
  output logic              proto_err
);

  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXEL_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WRITE     = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_next_s;
  logic              capture_s;
  logic              done_violation_s;

  logic              bram_ena_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic              flt_start_r;
  logic [7:0]        flt_red_r;
  logic [7:0]        flt_green_r;
  logic [7:0]        flt_blue_r;
  logic              out_we_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic [7:0]        out_red_r;
  logic [7:0]        out_green_r;
  logic [7:0]        out_blue_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              proto_err_r;

  // State and pixel index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Next-state, pixel index and handshake-violation decode
  always_comb begin
    state_next_s     = state_r;
    idx_next_s       = idx_r;
    capture_s        = 1'b0;
    done_violation_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        done_violation_s = flt_done;
        if (start) begin
          state_next_s = ST_FETCH;
          idx_next_s   = IDX_ZERO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        done_violation_s = flt_done;
        state_next_s     = ST_LATCH;
      end
      ST_LATCH: begin
        done_violation_s = flt_done;
        state_next_s     = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A done without ready is not a completion; keep waiting for ready.
        if (flt_ready && flt_done) begin
          state_next_s = ST_WRITE;
          capture_s    = 1'b1;
        end else if (flt_ready) begin
          state_next_s = ST_WAIT_DONE;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (flt_done) begin
          state_next_s = ST_WRITE;
          capture_s    = 1'b1;
        end else begin
          state_next_s = ST_WAIT_DONE;
        end
      end
      ST_WRITE: begin
        done_violation_s = flt_done;
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_FINISH;
          idx_next_s   = IDX_ZERO;
        end else begin
          state_next_s = ST_FETCH;
          idx_next_s   = idx_r + IDX_ONE;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_IDLE;
        idx_next_s   = IDX_ZERO;
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = IDX_ZERO;
      end
    endcase
  end

  // Input RAM read port, registered from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_ena_r  <= 1'b0;
      bram_addr_r <= IDX_ZERO;
    end else begin
      bram_ena_r <= (state_next_s == ST_FETCH);
      if (state_next_s == ST_FETCH) begin
        bram_addr_r <= idx_next_s;
      end
    end
  end

  // Filter operand latch and ap_start strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_start_r <= 1'b0;
      flt_red_r   <= 8'd0;
      flt_green_r <= 8'd0;
      flt_blue_r  <= 8'd0;
    end else begin
      flt_start_r <= (state_next_s == ST_ISSUE);
      if (state_r == ST_LATCH) begin
        flt_red_r   <= r_in;
        flt_green_r <= g_in;
        flt_blue_r  <= b_in;
      end
    end
  end

  // Output RAM write port; results are taken on the completing handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      out_we_r    <= 1'b0;
      out_addr_r  <= IDX_ZERO;
      out_red_r   <= 8'd0;
      out_green_r <= 8'd0;
      out_blue_r  <= 8'd0;
    end else begin
      out_we_r <= capture_s;
      if (capture_s) begin
        out_addr_r  <= idx_r;
        out_red_r   <= flt_new_red;
        out_green_r <= flt_new_green;
        out_blue_r  <= flt_new_blue;
      end
    end
  end

  // Status flags; proto_err is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      proto_err_r  <= 1'b0;
    end else begin
      busy_r       <= (state_next_s != ST_IDLE);
      frame_done_r <= (state_next_s == ST_FINISH);
      if (done_violation_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign bram_ena   = bram_ena_r;
  assign bram_addr  = bram_addr_r;
  assign flt_start  = flt_start_r;
  assign flt_red    = flt_red_r;
  assign flt_green  = flt_green_r;
  assign flt_blue   = flt_blue_r;
  assign out_we     = out_we_r;
  assign out_addr   = out_addr_r;
  assign out_red    = out_red_r;
  assign out_green  = out_green_r;
  assign out_blue   = out_blue_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign proto_err  = proto_err_r;

endmodule
